// File: rtl/i2c_ioexp_multi_if.sv
// Transaction handshake between the expander controller and the shared I2C engine.
interface i2c_ioexp_multi_if;
    logic       eng_start;
    logic [6:0] eng_addr;
    logic [1:0] eng_num_wr;
    logic [7:0] eng_wr_data0;
    logic [7:0] eng_wr_data1;
    logic [7:0] eng_wr_data2;
    logic [1:0] eng_num_rd;
    logic [7:0] eng_rd_data0;
    logic [7:0] eng_rd_data1;
    logic       eng_done;
    logic       eng_nack;

    modport master (
        output eng_start, eng_addr, eng_num_wr, eng_wr_data0, eng_wr_data1, eng_wr_data2,
        output eng_num_rd,
        input  eng_rd_data0, eng_rd_data1, eng_done, eng_nack
    );

    modport slave (
        input  eng_start, eng_addr, eng_num_wr, eng_wr_data0, eng_wr_data1, eng_wr_data2,
        input  eng_num_rd,
        output eng_rd_data0, eng_rd_data1, eng_done, eng_nack
    );
endinterface

// File: rtl/i2c_ioexp_multi.sv
// Round-robin controller for up to four PCAL6416A expanders behind one I2C engine.
module i2c_ioexp_multi #(
    parameter int unsigned NUM_DEV     = 2,
    parameter logic [6:0]  BASE_ADDR   = 7'h20,
    parameter logic [3:0]  DEV_EN      = 4'b0011,
    parameter logic [63:0] INPUT_MASK  = 64'h0,
    parameter int unsigned POLL_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [16*NUM_DEV-1:0]  out_data_i,
    input  logic [NUM_DEV-1:0]     irq_n_i,
    output logic [16*NUM_DEV-1:0]  in_data_o,
    output logic [NUM_DEV-1:0]     in_valid_o,
    output logic [NUM_DEV-1:0]     dev_fail_o,
    output logic                   ready_o,
    i2c_ioexp_multi_if.master      eng
);

    typedef enum logic [2:0] {
        StInitOut, StInitCfg, StInitRd, StScan, StIssue, StWaitDone, StNext
    } state_e;

    typedef enum logic [1:0] {TxOut, TxCfg, TxRd} kind_e;

    localparam logic [3:0]  DevMask    = (NUM_DEV >= 4) ? 4'hF : 4'((1 << NUM_DEV) - 1);
    localparam logic [3:0]  EnMask     = DEV_EN & DevMask;
    localparam logic [1:0]  LastDev    = 2'(NUM_DEV - 1);
    localparam logic [7:0]  MaxRetry   = 8'(MAX_RETRY);
    localparam logic [31:0] PollReload = 32'(POLL_CYCLES);

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    kind_e       kind_q, kind_d;
    logic [7:0]  retry_q, retry_d;
    logic [31:0] poll_q, poll_d;
    logic        ready_q, ready_d;
    logic [3:0]  dev_fail_q, dev_fail_d;
    logic [3:0]  read_req_q, read_req_d;
    logic [3:0]  in_valid_q, in_valid_d;
    logic [15:0] shadow_q [4];
    logic [15:0] shadow_d [4];
    logic [15:0] in_data_q [4];
    logic [15:0] in_data_d [4];
    logic [6:0]  addr_q, addr_d;
    logic [1:0]  num_wr_q, num_wr_d, num_rd_q, num_rd_d;
    logic [7:0]  wr0_q, wr0_d, wr1_q, wr1_d, wr2_q, wr2_d;

    logic [63:0] out_pad;
    logic [63:0] in_pad;
    logic [15:0] out_arr [4];
    logic [3:0]  irq_low;
    logic [15:0] cur_out, cur_cfg;
    logic [1:0]  ptr_nxt;
    logic        cur_en, cur_elig, need_wr, need_rd, retry_left, init_finish, poll_exp;
    logic        ld_out, ld_cfg, ld_rd;

    // Shared decode of the device under the round-robin pointer.
    always_comb begin
        out_pad = 64'(out_data_i);
        irq_low = 4'(~irq_n_i);
        for (int k = 0; k < 4; k++) begin
            out_arr[k] = out_pad[16*k +: 16];
        end
        cur_out    = out_arr[ptr_q];
        cur_cfg    = INPUT_MASK[{ptr_q, 4'b0000} +: 16];
        ptr_nxt    = (ptr_q == LastDev) ? 2'd0 : ptr_q + 2'd1;
        cur_en     = EnMask[ptr_q];
        cur_elig   = cur_en && !dev_fail_q[ptr_q];
        need_wr    = cur_elig && (cur_out != shadow_q[ptr_q]);
        need_rd    = cur_elig && read_req_q[ptr_q];
        retry_left = retry_q < MaxRetry;
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StInitOut;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // FSM next state; init walks devices in order, run mode visits one device per pass.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_finish = 1'b0;
        unique case (state_q)
            StInitOut: begin
                if (cur_en) begin
                    state_d = StIssue;
                end else begin
                    ptr_d = ptr_nxt;
                    if (ptr_q == LastDev) begin
                        state_d     = StScan;
                        init_finish = 1'b1;
                    end
                end
            end
            StInitCfg, StInitRd: state_d = StIssue;
            StScan: begin
                if (need_wr || need_rd) state_d = StIssue;
                else                    ptr_d   = ptr_nxt;
            end
            StIssue: state_d = StWaitDone;
            StWaitDone: begin
                if (eng.eng_done) begin
                    if (eng.eng_nack && retry_left) begin
                        state_d = StIssue;
                    end else if (ready_q) begin
                        state_d = StNext;
                    end else if (!eng.eng_nack && kind_q == TxOut) begin
                        state_d = StInitCfg;
                    end else if (!eng.eng_nack && kind_q == TxCfg) begin
                        state_d = StInitRd;
                    end else begin
                        // Init of this device is finished (read done or device failed).
                        ptr_d = ptr_nxt;
                        if (ptr_q == LastDev) begin
                            state_d     = StScan;
                            init_finish = 1'b1;
                        end else begin
                            state_d = StInitOut;
                        end
                    end
                end
            end
            StNext: begin
                ptr_d   = ptr_nxt;
                state_d = StScan;
            end
            default: state_d = StInitOut;
        endcase
    end

    // Datapath next state: transaction loading, completion bookkeeping, request tracking.
    always_comb begin
        kind_d     = kind_q;
        retry_d    = retry_q;
        poll_d     = poll_q;
        ready_d    = ready_q | init_finish;
        dev_fail_d = dev_fail_q;
        read_req_d = read_req_q;
        in_valid_d = '0;
        shadow_d   = shadow_q;
        in_data_d  = in_data_q;
        addr_d     = addr_q;
        num_wr_d   = num_wr_q;
        num_rd_d   = num_rd_q;
        wr0_d      = wr0_q;
        wr1_d      = wr1_q;
        wr2_d      = wr2_q;
        poll_exp   = 1'b0;

        if (POLL_CYCLES != 0) begin
            if (poll_q <= 32'd1) begin
                poll_exp = 1'b1;
                poll_d   = PollReload;
            end else begin
                poll_d = poll_q - 32'd1;
            end
        end

        // Output writes take priority over reads in run mode.
        ld_out = (state_q == StInitOut && cur_en) || (state_q == StScan && need_wr);
        ld_cfg = (state_q == StInitCfg);
        ld_rd  = (state_q == StInitRd) || (state_q == StScan && !need_wr && need_rd);

        if (ld_out || ld_cfg || ld_rd) begin
            addr_d  = BASE_ADDR + 7'(ptr_q);
            retry_d = 8'd0;
        end
        if (ld_out) begin
            kind_d   = TxOut;
            num_wr_d = 2'd3;
            num_rd_d = 2'd0;
            wr0_d    = 8'h02;
            wr1_d    = cur_out[7:0];
            wr2_d    = cur_out[15:8];
        end else if (ld_cfg) begin
            kind_d   = TxCfg;
            num_wr_d = 2'd3;
            num_rd_d = 2'd0;
            wr0_d    = 8'h06;
            wr1_d    = cur_cfg[7:0];
            wr2_d    = cur_cfg[15:8];
        end else if (ld_rd) begin
            kind_d   = TxRd;
            num_wr_d = 2'd1;
            num_rd_d = 2'd2;
            wr0_d    = 8'h00;
            wr1_d    = 8'h00;
            wr2_d    = 8'h00;
        end

        if (state_q == StWaitDone && eng.eng_done) begin
            if (!eng.eng_nack) begin
                if (kind_q == TxOut) begin
                    // Shadow holds what was sent, so a mid-transaction change rewrites later.
                    shadow_d[ptr_q] = {wr2_q, wr1_q};
                end else if (kind_q == TxRd) begin
                    in_data_d[ptr_q]  = {eng.eng_rd_data1, eng.eng_rd_data0};
                    in_valid_d[ptr_q] = 1'b1;
                    read_req_d[ptr_q] = 1'b0;
                end
            end else if (retry_left) begin
                retry_d = retry_q + 8'd1;
            end else begin
                dev_fail_d[ptr_q] = 1'b1;
            end
        end

        // New requests win over a same-cycle clear; failed devices drop all pending work.
        read_req_d = (read_req_d | ((irq_low | {4{poll_exp}}) & EnMask)) & ~dev_fail_d;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            kind_q     <= TxOut;
            retry_q    <= 8'd0;
            poll_q     <= PollReload;
            ready_q    <= 1'b0;
            dev_fail_q <= '0;
            read_req_q <= '0;
            in_valid_q <= '0;
            addr_q     <= '0;
            num_wr_q   <= '0;
            num_rd_q   <= '0;
            wr0_q      <= '0;
            wr1_q      <= '0;
            wr2_q      <= '0;
            for (int k = 0; k < 4; k++) begin
                shadow_q[k]  <= '0;
                in_data_q[k] <= '0;
            end
        end else begin
            kind_q     <= kind_d;
            retry_q    <= retry_d;
            poll_q     <= poll_d;
            ready_q    <= ready_d;
            dev_fail_q <= dev_fail_d;
            read_req_q <= read_req_d;
            in_valid_q <= in_valid_d;
            addr_q     <= addr_d;
            num_wr_q   <= num_wr_d;
            num_rd_q   <= num_rd_d;
            wr0_q      <= wr0_d;
            wr1_q      <= wr1_d;
            wr2_q      <= wr2_d;
            shadow_q   <= shadow_d;
            in_data_q  <= in_data_d;
        end
    end

    // Outputs: start pulse decoded from state, everything else straight from registers.
    always_comb begin
        eng.eng_start    = (state_q == StIssue);
        eng.eng_addr     = addr_q;
        eng.eng_num_wr   = num_wr_q;
        eng.eng_num_rd   = num_rd_q;
        eng.eng_wr_data0 = wr0_q;
        eng.eng_wr_data1 = wr1_q;
        eng.eng_wr_data2 = wr2_q;
        ready_o          = ready_q;
        in_pad           = '0;
        for (int k = 0; k < 4; k++) begin
            in_pad[16*k +: 16] = in_data_q[k];
        end
        in_data_o  = in_pad[16*NUM_DEV-1:0];
        in_valid_o = in_valid_q[NUM_DEV-1:0];
        dev_fail_o = dev_fail_q[NUM_DEV-1:0];
    end

endmodule

// File: tb/tb_i2c_ioexp_multi.sv
// Randomised bench: behavioural I2C engine plus transaction log checked against expectations.
module tb_i2c_ioexp_multi;

    localparam logic [63:0] InMask = 64'h0000_0000_00FF_0000;

    typedef struct {
        logic [6:0] addr;
        logic [1:0] nwr;
        logic [7:0] b0, b1, b2;
        logic [1:0] nrd;
        logic       nack;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] out_data;
    logic [1:0]  irq_n;
    logic [31:0] in_data;
    logic [1:0]  in_valid;
    logic [1:0]  dev_fail;
    logic        ready;

    int   n_checks = 0;
    int   n_fail   = 0;
    txn_t log_q[$];

    // Engine model state
    bit          busy = 1'b0;
    bit          hold = 1'b0;
    int          wait_cnt;
    txn_t        cur;
    logic [15:0] dev_in [2];
    logic [1:0]  nack_dev = 2'b00;
    logic [1:0]  exp_valid;
    logic [15:0] exp_in [2];

    i2c_ioexp_multi_if eng_if ();

    i2c_ioexp_multi #(
        .NUM_DEV     (2),
        .BASE_ADDR   (7'h20),
        .DEV_EN      (4'b0011),
        .INPUT_MASK  (InMask),
        .POLL_CYCLES (100),
        .MAX_RETRY   (3)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .out_data_i (out_data),
        .irq_n_i    (irq_n),
        .in_data_o  (in_data),
        .in_valid_o (in_valid),
        .dev_fail_o (dev_fail),
        .ready_o    (ready),
        .eng        (eng_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tx_key(input logic [6:0] a, input logic [1:0] nw,
                                           input logic [7:0] x0, input logic [7:0] x1,
                                           input logic [7:0] x2, input logic [1:0] nr);
        if (nr != 2'd0) return {29'd0, a, nw, x0, 16'h0000, nr};
        return {29'd0, a, nw, x0, x1, x2, nr};
    endfunction

    function automatic logic [63:0] key_of(input txn_t t);
        return tx_key(t.addr, t.nwr, t.b0, t.b1, t.b2, t.nrd);
    endfunction

    function automatic logic [63:0] exp_wr(input int k, input logic [7:0] rg, input logic [15:0] w);
        return tx_key(7'h20 + 7'(k), 2'd3, rg, w[7:0], w[15:8], 2'd0);
    endfunction

    function automatic logic [63:0] exp_rd(input int k);
        return tx_key(7'h20 + 7'(k), 2'd1, 8'h00, 8'h00, 8'h00, 2'd2);
    endfunction

    // Behavioural engine: random latency, per-device NACK mode, in_valid/in_data scoreboard.
    initial begin
        int idx;
        eng_if.eng_done     = 1'b0;
        eng_if.eng_nack     = 1'b0;
        eng_if.eng_rd_data0 = 8'h00;
        eng_if.eng_rd_data1 = 8'h00;
        exp_valid           = 2'b00;
        exp_in[0]           = 16'h0;
        exp_in[1]           = 16'h0;
        forever begin
            @(negedge clk);
            eng_if.eng_done = 1'b0;
            eng_if.eng_nack = 1'b0;
            if (rst) begin
                busy      = 1'b0;
                exp_valid = 2'b00;
                continue;
            end
            check_eq("in_valid", 64'(in_valid), 64'(exp_valid));
            for (int k = 0; k < 2; k++) begin
                if (exp_valid[k]) check_eq("in_data", 64'(in_data[16*k +: 16]), 64'(exp_in[k]));
            end
            exp_valid = 2'b00;
            if (busy) begin
                check_eq("start_pulse", 64'(eng_if.eng_start), 64'd0);
                check_eq("bus_stable",
                         64'({eng_if.eng_addr, eng_if.eng_num_wr, eng_if.eng_wr_data0,
                              eng_if.eng_wr_data1, eng_if.eng_wr_data2, eng_if.eng_num_rd}),
                         64'({cur.addr, cur.nwr, cur.b0, cur.b1, cur.b2, cur.nrd}));
                if (!hold) begin
                    if (wait_cnt == 0) begin
                        idx      = int'(cur.addr) - 32'h20;
                        cur.nack = (idx >= 0 && idx < 2) ? nack_dev[idx] : 1'b1;
                        if (!cur.nack && cur.nrd == 2'd2) begin
                            eng_if.eng_rd_data0 = dev_in[idx][7:0];
                            eng_if.eng_rd_data1 = dev_in[idx][15:8];
                            if (cur.nwr == 2'd1 && cur.b0 == 8'h00) begin
                                exp_valid[idx] = 1'b1;
                                exp_in[idx]    = dev_in[idx];
                            end
                        end
                        eng_if.eng_done = 1'b1;
                        eng_if.eng_nack = cur.nack;
                        log_q.push_back(cur);
                        busy = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end else if (eng_if.eng_start) begin
                cur.addr = eng_if.eng_addr;
                cur.nwr  = eng_if.eng_num_wr;
                cur.b0   = eng_if.eng_wr_data0;
                cur.b1   = eng_if.eng_wr_data1;
                cur.b2   = eng_if.eng_wr_data2;
                cur.nrd  = eng_if.eng_num_rd;
                cur.nack = 1'b0;
                busy     = 1'b1;
                wait_cnt = int'($urandom_range(0, 3));
            end
        end
    end

    task automatic wait_ready(input string tag);
        for (int c = 0; c < 600 && !ready; c++) @(negedge clk);
        check_eq(tag, 64'(ready), 64'd1);
    endtask

    // Expected init sequence derived from the requested outputs and the input mask.
    task automatic check_init();
        check_eq("init_count", 64'(log_q.size() >= 6), 64'd1);
        if (log_q.size() >= 6) begin
            for (int k = 0; k < 2; k++) begin
                check_eq("init_out", key_of(log_q[3*k]), exp_wr(k, 8'h02, out_data[16*k +: 16]));
                check_eq("init_cfg", key_of(log_q[3*k+1]), exp_wr(k, 8'h06, InMask[16*k +: 16]));
                check_eq("init_rd", key_of(log_q[3*k+2]), exp_rd(k));
            end
        end
    endtask

    initial begin
        logic [1:0]  chg;
        logic [15:0] nv;
        int          nwr, nrd0, nrd1, n21, idx;

        rst       = 1'b1;
        out_data  = {16'hBEEF, 16'h1234};
        irq_n     = 2'b11;
        dev_in[0] = 16'($urandom);
        dev_in[1] = 16'($urandom);
        repeat (3) @(negedge clk);
        check_eq("rst_start", 64'(eng_if.eng_start), 64'd0);
        check_eq("rst_bus", 64'({eng_if.eng_addr, eng_if.eng_num_wr, eng_if.eng_wr_data0,
                                 eng_if.eng_wr_data1, eng_if.eng_wr_data2, eng_if.eng_num_rd}),
                 64'd0);
        check_eq("rst_outs", 64'({ready, dev_fail, in_valid, in_data}), 64'd0);
        rst = 1'b0;

        // Init: six transactions in device order, then ready.
        wait_ready("init_ready");
        check_init();
        check_eq("init_fail", 64'(dev_fail), 64'd0);

        // One output change produces exactly one write, only to device 0.
        log_q.delete();
        out_data[15:0] = 16'h5678;
        repeat (60) @(negedge clk);
        nwr = 0;
        foreach (log_q[i]) if (log_q[i].nrd == 2'd0) begin
            nwr++;
            check_eq("chg_wr", key_of(log_q[i]), exp_wr(0, 8'h02, 16'h5678));
        end
        check_eq("chg_wr_cnt", 64'(nwr), 64'd1);

        // Random output changes on random device subsets.
        for (int it = 0; it < 6; it++) begin
            log_q.delete();
            chg = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) if (chg[k]) begin
                nv = 16'($urandom);
                if (nv == out_data[16*k +: 16]) nv = nv ^ 16'h0001;
                out_data[16*k +: 16] = nv;
            end
            repeat (80) @(negedge clk);
            nwr = 0;
            foreach (log_q[i]) if (log_q[i].nrd == 2'd0) begin
                nwr++;
                idx = int'(log_q[i].addr[0]);
                check_eq("rnd_wr_dev", 64'({log_q[i].addr[6:1], chg[idx]}), 64'({6'h10, 1'b1}));
                check_eq("rnd_wr", key_of(log_q[i]), exp_wr(idx, 8'h02, out_data[16*idx +: 16]));
            end
            check_eq("rnd_wr_cnt", 64'(nwr), 64'($countones(chg)));
        end

        // Interrupt held low: repeated reads of device 1.
        log_q.delete();
        dev_in[1] = 16'h3CA5;
        irq_n[1]  = 1'b0;
        repeat (100) @(negedge clk);
        n21 = 0;
        foreach (log_q[i]) if (log_q[i].addr == 7'h21) begin
            n21++;
            check_eq("irq_rd", key_of(log_q[i]), exp_rd(1));
        end
        check_eq("irq_rd_many", 64'(n21 >= 4), 64'd1);
        check_eq("irq_data", 64'(in_data[31:16]), 64'h3CA5);
        irq_n[1] = 1'b1;
        repeat (20) @(negedge clk);

        // Idle bus: one read per device per 100-cycle poll.
        log_q.delete();
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (c % 37 == 0) begin
                dev_in[0] = 16'($urandom);
                dev_in[1] = 16'($urandom);
            end
        end
        nrd0 = 0;
        nrd1 = 0;
        foreach (log_q[i]) begin
            if (key_of(log_q[i]) == exp_rd(0)) nrd0++;
            if (key_of(log_q[i]) == exp_rd(1)) nrd1++;
        end
        check_eq("poll_cnt0", 64'(nrd0 >= 9 && nrd0 <= 11), 64'd1);
        check_eq("poll_cnt1", 64'(nrd1 >= 9 && nrd1 <= 11), 64'd1);
        check_eq("poll_total", 64'(log_q.size()), 64'(nrd0 + nrd1));

        // Device 1 NACKs everything: four attempts, then flagged and skipped.
        log_q.delete();
        nack_dev[1] = 1'b1;
        irq_n[1]    = 1'b0;
        @(negedge clk);
        irq_n[1] = 1'b1;
        for (int c = 0; c < 300 && !dev_fail[1]; c++) @(negedge clk);
        check_eq("nack_fail", 64'(dev_fail), 64'b10);
        repeat (10) @(negedge clk);
        n21 = 0;
        foreach (log_q[i]) if (log_q[i].addr == 7'h21) begin
            n21++;
            check_eq("nack_flag", 64'(log_q[i].nack), 64'd1);
        end
        check_eq("nack_attempts", 64'(n21), 64'd4);
        check_eq("nack_ready", 64'(ready), 64'd1);

        log_q.delete();
        out_data = {16'($urandom), ~out_data[15:0]};
        repeat (300) @(negedge clk);
        n21  = 0;
        nwr  = 0;
        nrd0 = 0;
        foreach (log_q[i]) begin
            if (log_q[i].addr == 7'h21) n21++;
            if (log_q[i].nrd == 2'd0) begin
                nwr++;
                check_eq("post_fail_wr", key_of(log_q[i]), exp_wr(0, 8'h02, out_data[15:0]));
            end
            if (key_of(log_q[i]) == exp_rd(0)) nrd0++;
        end
        check_eq("post_fail_21", 64'(n21), 64'd0);
        check_eq("post_fail_wrcnt", 64'(nwr), 64'd1);
        check_eq("post_fail_rd0", 64'(nrd0 >= 2), 64'd1);

        // Reset while a transaction is outstanding.
        hold           = 1'b1;
        out_data[15:0] = out_data[15:0] ^ 16'h0F0F;
        for (int c = 0; c < 200 && !busy; c++) @(negedge clk);
        check_eq("hold_busy", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);
        check_eq("inflight_addr", 64'(eng_if.eng_addr), 64'h20);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_start", 64'(eng_if.eng_start), 64'd0);
        check_eq("arst_bus", 64'({eng_if.eng_addr, eng_if.eng_num_wr, eng_if.eng_wr_data0,
                                  eng_if.eng_wr_data1, eng_if.eng_wr_data2, eng_if.eng_num_rd}),
                 64'd0);
        check_eq("arst_outs", 64'({ready, dev_fail, in_valid, in_data}), 64'd0);
        @(negedge clk);
        hold     = 1'b0;
        nack_dev = 2'b00;
        @(negedge clk);
        log_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ready("reinit_ready");
        check_init();
        check_eq("reinit_fail", 64'(dev_fail), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/i2c_ioexp_multi.md
# i2c_ioexp_multi

Parametrised controller for up to 4 PCAL6416A I2C I/O expanders that share one I2C transaction engine (i2c_basic). It initialises each enabled device, mirrors per-device 16-bit output words to the expanders on change, and reads input ports back on interrupt or periodic poll. Devices are serviced round-robin. Transactions that NACK are retried, and a device that keeps failing is flagged and skipped. Sits between board-level control logic and the i2c_basic engine.

## Interface
- NUM_DEV, 2: number of expanders, 1..4; device k is at 7-bit address BASE_ADDR+k
- BASE_ADDR, 7'h20: I2C address of device 0
- DEV_EN, 4'b0011: per-device enable; disabled devices are never addressed
- INPUT_MASK, 64'h0: 16 bits per device, device k at [16k+15:16k]; 1 = pin is an input (config register value)
- POLL_CYCLES, 1_000_000: input-poll interval in clk cycles; 0 disables polling
- MAX_RETRY, 3: retries after a NACK before the device is flagged failed
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- out_data  in  16*NUM_DEV  requested output pin values, device k at [16k+15:16k]
- irq_n  in  NUM_DEV  active-low expander interrupts, already synchronised to clk
- in_data  out  16*NUM_DEV  last input-port value read per device
- in_valid  out  NUM_DEV  one-cycle pulse when in_data[k] updates
- dev_fail  out  NUM_DEV  sticky; device exceeded MAX_RETRY
- ready  out  1  high once every enabled device has completed or failed init
- eng_start  out  1  one-cycle pulse that launches an engine transaction
- eng_addr  out  7  target address
- eng_num_wr  out  2  bytes to write (1..3)
- eng_wr_data0/1/2  out  8 each  register pointer, then data bytes
- eng_num_rd  out  2  bytes to read (0 or 2)
- eng_rd_data0/1  in  8 each  read bytes; valid in the eng_done cycle
- eng_done  in  1  one-cycle pulse; transaction finished
- eng_nack  in  1  qualified by eng_done; 1 = the transaction NACKed

## Operation
- Registers used: 0x00 input (2 bytes), 0x02 output (2 bytes), 0x06 configuration (2 bytes). Low byte is written first.
- INIT: for each enabled k in ascending order:
  - write {0x02, out_data[k] lo, hi}, then latch shadow[k] = the sent value;
  - then write {0x06, INPUT_MASK[k] lo, hi};
  - then do one input read.
  - ready rises after the last device is done.
- RUN: a round-robin pointer p visits the enabled, non-failed devices. For device p, priority is:
  1. write: out_data[p] != shadow[p] sends {0x02, lo, hi}. Shadow takes the transmitted value, so a change made mid-transaction causes another write on the next visit.
  2. read: sticky read_req[p] is set. The engine sends num_wr=1 {0x00} and num_rd=2. On done without NACK, in_data[p] = {rd_data1, rd_data0}, in_valid[p] pulses, and read_req[p] clears.
  3. none: advance p.
- read_req[k] is set when irq_n[k] is low (level) or the poll counter expires. Expiry sets read_req for all enabled devices and reloads the counter.
- After each transaction, p advances to the next eligible device. At most one transaction runs per device visit.
- NACK: retry the same transaction immediately, up to MAX_RETRY times. After that, set dev_fail[k], drop its pending work, and advance. A failed device is excluded until reset.
- States: INIT_OUT, INIT_CFG, INIT_RD, SCAN, ISSUE, WAIT_DONE, NEXT. ISSUE drives eng_start for one cycle. WAIT_DONE holds until eng_done.

## Timing
- Reset values: eng_start=0, all eng_* data=0, in_data=0, in_valid=0, dev_fail=0, ready=0, shadow=0, read_req=0, poll counter=POLL_CYCLES, state=INIT_OUT, p=0.
- eng_addr, eng_num_*, and eng_wr_data* are registered. They are valid in the eng_start cycle and held stable until the eng_done cycle.
- eng_start is asserted no earlier than 1 cycle after the prior eng_done; minimum gap is 1 cycle.
- in_valid[k] is asserted the cycle after eng_done; in_data updates in the same cycle.
- With no work pending, SCAN visits one device per cycle.
- An eng_done that arrives while not in WAIT_DONE is ignored.
- A reset assertion mid-transaction aborts immediately to reset values. The engine is reset by the same signal.
- irq_n low and a poll expiry in the same cycle produce a single read.
- NUM_DEV=1: p stays at 0.
- All devices failed: stays in SCAN, issues no starts, and ready stays 1.

## Test plan
- NUM_DEV=2, out_data={16'hBEEF,16'h1234}, INPUT_MASK dev1=16'h00FF. Required response: 6 init transactions in order (0x20 outputs 34 12, 0x20 config 00 00, 0x20 read, 0x21 outputs EF BE, 0x21 config FF 00, 0x21 read), then ready=1.
- After ready, change device 0's out_data to 16'h5678. Required response: exactly one write {0x02,0x78,0x56} to 0x20, and no traffic to 0x21.
- Pull irq_n[1] low; the model returns rd 0xA5, 0x3C. Required response: read from 0x21, in_data[1]=16'h3CA5, in_valid[1] pulses once per read. Reads repeat while irq_n stays low.
- POLL_CYCLES=100, idle bus. Required response: each enabled device is read once per 100-cycle expiry, in round-robin order.
- Device 1 always NACKs, MAX_RETRY=3. Required response: 4 attempts, then dev_fail[1]=1; device 0 keeps being serviced and 0x21 is never addressed again.
- Assert reset during WAIT_DONE. Required response: all outputs return to reset values within the same cycle, and init restarts from device 0 after reset deasserts.
